// File: rtl/keypad_pkg.sv
// Shared types, column patterns and key-code helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    function automatic logic [3:0] mk_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    // Lowest-indexed active-low row; only meaningful when at least one row is low.
    function automatic logic [1:0] low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Column-slot divider: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module keypad_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int              CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, press/release
// debounce, one-cycle key_valid pulse and a key_held level.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            DW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_SCANS - 1);

    state_t        state;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [1:0]    col_idx;
    logic [1:0]    cand_row;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] rel_cnt;
    logic [3:0]    col_next;
    logic          tick;
    logic          run;

    // The divider is held while the column register is idle, so the restart
    // cycle after scan_en rises still gives column 0 a full slot.
    assign run      = scan_en && (col_n != COL_IDLE);
    assign col_next = {col_n[2:0], col_n[3]};

    keypad_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // NOTE: non-blocking assignments make these two stages a true 2-FF chain;
    // blocking ones would collapse them into a single flop in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_n     <= COL_FIRST;
            col_idx   <= 2'd0;
            cand_row  <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!scan_en) begin
                state    <= SCAN;
                col_n    <= COL_IDLE;
                col_idx  <= 2'd0;
                deb_cnt  <= '0;
                rel_cnt  <= '0;
                key_held <= 1'b0;
            end else if (col_n == COL_IDLE) begin
                col_n   <= COL_FIRST;
                col_idx <= 2'd0;
            end else if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_sync != 4'hF) begin
                            cand_row <= low_row(row_sync);
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= mk_code(low_row(row_sync), col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= CNT_ONE;
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            col_n   <= col_next;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!row_sync[cand_row]) begin
                            if (deb_cnt == CNT_LAST) begin
                                key_code  <= mk_code(cand_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + CNT_ONE;
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= SCAN;
                            col_n   <= col_next;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    HELD: begin
                        if (row_sync[cand_row]) begin
                            if (rel_cnt == CNT_LAST) begin
                                rel_cnt  <= '0;
                                key_held <= 1'b0;
                                state    <= SCAN;
                                col_n    <= col_next;
                                col_idx  <= col_idx + 2'd1;
                            end else begin
                                rel_cnt <= rel_cnt + CNT_ONE;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: keypad model driven by col_n,
// scoreboard of expected key pulses (code and, where known, arrival cycle).
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    typedef struct {
        logic [3:0] code;
        int         due;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             scan_en;
    logic [3:0]       row_n;
    logic [3:0]       col_n;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             key_held;
    logic [3:0][3:0]  pressed;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    keypad_matrix_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to its column only while that column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : pulse_monitor
        exp_t e;
        if (!reset && key_valid === 1'b1) begin
            check("pulse_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pulse_code", key_code, e.code);
                if (e.due >= 0) check("pulse_cycle", cyc, e.due);
                check("held_on_pulse", key_held, 1);
            end
        end
    end

    task automatic wait_col(input logic [3:0] pat, output int at_cyc);
        int n;
        n = 0;
        while (col_n !== pat && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (col_n !== pat) check("wait_col", col_n, pat);
        at_cyc = cyc;
    endtask

    task automatic wait_held(input logic val, output int at_cyc);
        int n;
        n = 0;
        while (key_held !== val && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (key_held !== val) check("wait_held", key_held, val);
        at_cyc = cyc;
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) check("pulse_timeout", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int n0;
        cyc     = 0;
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        scan_en = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);

        check("rst_col", col_n, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);

        // Column rotation, one full slot per column.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("slot0_hold", col_n, 4'b1110);
        @(negedge clk);
        check("rot_col1", col_n, 4'b1101);
        repeat (4) @(negedge clk);
        check("rot_col2", col_n, 4'b1011);
        repeat (4) @(negedge clk);
        check("rot_col3", col_n, 4'b0111);
        repeat (4) @(negedge clk);
        check("rot_wrap", col_n, 4'b1110);

        // Clean press of (row1,col2): capture at the slot's last cycle, pulse 9 cycles later.
        pressed[1][2] = 1'b1;
        wait_col(4'b1011, n0);
        sb_q.push_back('{code: 4'h6, due: n0 + 3 + 2 * SCAN_DIV + 1});
        wait_sb_empty(100);
        check("press_held", key_held, 1);
        check("press_col_frozen", col_n, 4'b1011);
        repeat (50 * SCAN_DIV) @(negedge clk);
        check("hold_held", key_held, 1);
        check("hold_col", col_n, 4'b1011);

        // Single-tick release glitches must each reset the release count.
        for (int g = 0; g < 3; g++) begin
            pressed[1][2] = 1'b0;
            repeat (SCAN_DIV) @(negedge clk);
            pressed[1][2] = 1'b1;
            repeat (2 * SCAN_DIV) @(negedge clk);
        end
        check("glitch_held", key_held, 1);
        check("glitch_col", col_n, 4'b1011);

        pressed[1][2] = 1'b0;
        wait_held(1'b0, n0);
        check("release_next_col", col_n, 4'b0111);
        check("release_code_kept", key_code, 4'h6);

        // Bounce on (row3,col0): low one tick, high one tick, then stable.
        pressed[3][0] = 1'b1;
        wait_col(4'b1110, n0);
        repeat (SCAN_DIV) @(negedge clk);
        pressed[3][0] = 1'b0;
        repeat (SCAN_DIV) @(negedge clk);
        check("bounce_abort_col", col_n, 4'b1101);
        check("bounce_no_held", key_held, 0);
        pressed[3][0] = 1'b1;
        sb_q.push_back('{code: 4'hC, due: n0 + 2 * SCAN_DIV + 3 * SCAN_DIV + 3 + 2 * SCAN_DIV + 1});
        wait_sb_empty(100);
        check("bounce_held", key_held, 1);
        check("bounce_col", col_n, 4'b1110);

        // Two keys in column 1: the lower row index wins.
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        pressed[3][0] = 1'b0;
        wait_held(1'b0, n0);
        check("dual_resume_col", col_n, 4'b1101);
        sb_q.push_back('{code: 4'h1, due: n0 + 3 + 2 * SCAN_DIV + 1});
        wait_sb_empty(100);
        check("dual_held", key_held, 1);
        pressed[0][1] = 1'b0;
        pressed[2][1] = 1'b0;
        wait_held(1'b0, n0);
        check("dual_release_col", col_n, 4'b1011);

        // Reset in the middle of a debounce discards the press.
        pressed[1][3] = 1'b1;
        wait_col(4'b0111, n0);
        repeat (2 * SCAN_DIV + 1) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_col", col_n, 4'b1110);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 4'h0);
        pressed[1][3] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Press (row2,col2), then disable scanning while held.
        pressed[2][2] = 1'b1;
        sb_q.push_back('{code: 4'hA, due: -1});
        wait_sb_empty(100);
        scan_en = 1'b0;
        @(negedge clk);
        check("dis_col", col_n, 4'b1111);
        check("dis_held", key_held, 0);
        check("dis_valid", key_valid, 0);
        check("dis_code_kept", key_code, 4'hA);
        repeat (20) @(negedge clk);
        check("dis_col_stays", col_n, 4'b1111);
        pressed[2][2] = 1'b0;

        scan_en = 1'b1;
        @(negedge clk);
        check("reen_col", col_n, 4'b1110);
        repeat (SCAN_DIV - 1) @(negedge clk);
        check("reen_full_slot", col_n, 4'b1110);
        @(negedge clk);
        check("reen_advance", col_n, 4'b1101);
        repeat (4 * SCAN_DIV) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
